// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and types for the register file and rename table
package reg_file_pkg;
  localparam int REG_NUM = 32;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH = 5;
  localparam int REG_ADDR_WIDTH = 5;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: commit bus, issue rename and source lookup signals of the register file
interface reg_file_if;
  import reg_file_pkg::*;
  logic en_commit_in;
  tag_t commit_rob_in;
  addr_t commit_rd_in;
  data_t commit_val_in;
  logic issue_in;
  addr_t issue_rd_in;
  tag_t issue_rob_in;
  addr_t rs1_addr_in;
  addr_t rs2_addr_in;
  data_t rs1_val;
  data_t rs2_val;
  logic rs1_busy;
  logic rs2_busy;
  tag_t rs1_tag;
  tag_t rs2_tag;
  modport master (
    output en_commit_in, commit_rob_in, commit_rd_in, commit_val_in,
    output issue_in, issue_rd_in, issue_rob_in, rs1_addr_in, rs2_addr_in,
    input rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
  modport slave (
    input en_commit_in, commit_rob_in, commit_rd_in, commit_val_in,
    input issue_in, issue_rd_in, issue_rob_in, rs1_addr_in, rs2_addr_in,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/reg_file_lookup.sv
// reg_file_lookup: one source read port with same-cycle commit bypass
module reg_file_lookup
  import reg_file_pkg::*;
(
  input  addr_t                  rs,
  input  data_t [REG_NUM-1:0]    reg_val,
  input  logic  [REG_NUM-1:0]    reg_busy,
  input  tag_t  [REG_NUM-1:0]    reg_tag,
  input  logic                   en_commit,
  input  addr_t                  commit_rd,
  input  tag_t                   commit_rob,
  input  data_t                  commit_val,
  output data_t                  rs_val,
  output logic                   rs_busy,
  output tag_t                   rs_tag
);
  logic hit;
  // only the commit of the pending producer may forward; an older writer's value is stale
  assign hit = en_commit && commit_rd == rs && rs != '0 && reg_busy[rs] && reg_tag[rs] == commit_rob;
  assign rs_val = hit ? commit_val : reg_val[rs];
  assign rs_busy = reg_busy[rs] && !hit;
  assign rs_tag = reg_tag[rs];
endmodule

// File: rtl/reg_file.sv
// reg_file: architectural registers plus rename status table fed by ROB commit and issue
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk_in,
  input logic       rst_in,
  input logic       rdy_in,
  input logic       clear_in,
  reg_file_if.slave bus
);
  data_t [REG_NUM-1:0] reg_val;
  logic  [REG_NUM-1:0] reg_busy;
  tag_t  [REG_NUM-1:0] reg_tag;
  // x0 is never touched: loop starts at 1, so its entry stays at reset zero
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      reg_val <= '0;
      reg_busy <= '0;
      reg_tag <= '0;
    end else if (rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.en_commit_in && bus.commit_rd_in == addr_t'(i)) reg_val[i] <= bus.commit_val_in;
        if (clear_in) reg_busy[i] <= 1'b0;
        else if (bus.issue_in && bus.issue_rd_in == addr_t'(i)) begin
          reg_busy[i] <= 1'b1;
          reg_tag[i] <= bus.issue_rob_in;
        end else if (bus.en_commit_in && bus.commit_rd_in == addr_t'(i) && reg_tag[i] == bus.commit_rob_in)
          reg_busy[i] <= 1'b0;
      end
    end
  reg_file_lookup u_rs1 (
    .rs(bus.rs1_addr_in), .reg_val(reg_val), .reg_busy(reg_busy), .reg_tag(reg_tag),
    .en_commit(bus.en_commit_in), .commit_rd(bus.commit_rd_in), .commit_rob(bus.commit_rob_in),
    .commit_val(bus.commit_val_in), .rs_val(bus.rs1_val), .rs_busy(bus.rs1_busy), .rs_tag(bus.rs1_tag)
  );
  reg_file_lookup u_rs2 (
    .rs(bus.rs2_addr_in), .reg_val(reg_val), .reg_busy(reg_busy), .reg_tag(reg_tag),
    .en_commit(bus.en_commit_in), .commit_rd(bus.commit_rd_in), .commit_rob(bus.commit_rob_in),
    .commit_val(bus.commit_val_in), .rs_val(bus.rs2_val), .rs_busy(bus.rs2_busy), .rs_tag(bus.rs2_tag)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic clear_in = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  reg_file_if bus ();
  reg_file dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  task automatic idle();
    rdy_in = 1'b1;
    clear_in = 1'b0;
    bus.en_commit_in = 1'b0;
    bus.commit_rob_in = '0;
    bus.commit_rd_in = '0;
    bus.commit_val_in = '0;
    bus.issue_in = 1'b0;
    bus.issue_rd_in = '0;
    bus.issue_rob_in = '0;
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic commit(input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] v);
    bus.en_commit_in = 1'b1;
    bus.commit_rd_in = rd;
    bus.commit_rob_in = rob;
    bus.commit_val_in = v;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [4:0] rob);
    bus.issue_in = 1'b1;
    bus.issue_rd_in = rd;
    bus.issue_rob_in = rob;
  endtask
  task automatic test_reset();
    idle();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    bus.rs1_addr_in = 5'd7;
    bus.rs2_addr_in = 5'd31;
    #1;
    n_checks++; if (bus.rs1_val !== 32'h0) begin n_fail++; $display("FAIL reset_val: got %h want %h", bus.rs1_val, 32'h0); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.rs1_busy); end
    n_checks++; if (bus.rs1_tag !== 5'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", bus.rs1_tag); end
    n_checks++; if (bus.rs2_val !== 32'h0 || bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs2: got %h/%b want 0/0", bus.rs2_val, bus.rs2_busy); end
  endtask
  task automatic test_rename();
    issue(5'd7, 5'd3);
    bus.rs1_addr_in = 5'd7;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL rename_same_cycle_busy: got %b want 0", bus.rs1_busy); end
    step();
    idle();
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL rename_busy: got %b want 1", bus.rs1_busy); end
    n_checks++; if (bus.rs1_tag !== 5'd3) begin n_fail++; $display("FAIL rename_tag: got %0d want 3", bus.rs1_tag); end
  endtask
  task automatic test_commit_bypass();
    commit(5'd7, 5'd3, 32'hDEADBEEF);
    bus.rs1_addr_in = 5'd7;
    bus.rs2_addr_in = 5'd7;
    #1;
    n_checks++; if (bus.rs1_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_val: got %h want %h", bus.rs1_val, 32'hDEADBEEF); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_busy: got %b want 0", bus.rs1_busy); end
    n_checks++; if (bus.rs2_val !== 32'hDEADBEEF || bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL bypass_rs2: got %h/%b want deadbeef/0", bus.rs2_val, bus.rs2_busy); end
    step();
    idle();
    #1;
    n_checks++; if (bus.rs1_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL commit_stored_val: got %h want %h", bus.rs1_val, 32'hDEADBEEF); end
    n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL commit_stored_busy: got %b want 0", bus.rs1_busy); end
  endtask
  task automatic test_younger_writer();
    issue(5'd7, 5'd3);
    step();
    issue(5'd7, 5'd9);
    step();
    idle();
    commit(5'd7, 5'd3, 32'h11);
    bus.rs1_addr_in = 5'd7;
    #1;
    n_checks++; if (bus.rs1_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL younger_no_bypass_val: got %h want %h", bus.rs1_val, 32'hDEADBEEF); end
    n_checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 5'd9) begin n_fail++; $display("FAIL younger_no_bypass_busy: got %b/%0d want 1/9", bus.rs1_busy, bus.rs1_tag); end
    step();
    idle();
    #1;
    n_checks++; if (bus.rs1_val !== 32'h11) begin n_fail++; $display("FAIL younger_val: got %h want %h", bus.rs1_val, 32'h11); end
    n_checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 5'd9) begin n_fail++; $display("FAIL younger_busy_tag: got %b/%0d want 1/9", bus.rs1_busy, bus.rs1_tag); end
  endtask
  task automatic test_commit_issue_same();
    commit(5'd7, 5'd3, 32'h22);
    issue(5'd7, 5'd4);
    step();
    idle();
    bus.rs1_addr_in = 5'd7;
    #1;
    n_checks++; if (bus.rs1_val !== 32'h22) begin n_fail++; $display("FAIL same_cycle_val: got %h want %h", bus.rs1_val, 32'h22); end
    n_checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 5'd4) begin n_fail++; $display("FAIL same_cycle_busy_tag: got %b/%0d want 1/4", bus.rs1_busy, bus.rs1_tag); end
    commit(5'd7, 5'd4, 32'h33);
    issue(5'd7, 5'd8);
    step();
    idle();
    #1;
    n_checks++; if (bus.rs1_val !== 32'h33 || bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 5'd8) begin n_fail++; $display("FAIL same_cycle_match: got %h/%b/%0d want 33/1/8", bus.rs1_val, bus.rs1_busy, bus.rs1_tag); end
  endtask
  task automatic test_clear();
    for (int r = 1; r <= 5; r++) begin
      issue(5'(r), 5'(10 + r));
      step();
    end
    idle();
    bus.rs1_addr_in = 5'd3;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 5'd13) begin n_fail++; $display("FAIL clear_setup: got %b/%0d want 1/13", bus.rs1_busy, bus.rs1_tag); end
    clear_in = 1'b1;
    commit(5'd1, 5'd20, 32'h1000);
    issue(5'd6, 5'd21);
    step();
    idle();
    for (int r = 1; r <= 7; r++) begin
      bus.rs1_addr_in = 5'(r);
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_x%0d: got %b want 0", r, bus.rs1_busy); end
    end
    bus.rs2_addr_in = 5'd1;
    #1;
    n_checks++; if (bus.rs2_val !== 32'h1000) begin n_fail++; $display("FAIL clear_commit_val: got %h want %h", bus.rs2_val, 32'h1000); end
  endtask
  task automatic test_x0();
    commit(5'd0, 5'd2, 32'h55);
    issue(5'd0, 5'd2);
    bus.rs1_addr_in = 5'd0;
    #1;
    n_checks++; if (bus.rs1_val !== 32'h0 || bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_same_cycle: got %h/%b want 0/0", bus.rs1_val, bus.rs1_busy); end
    step();
    idle();
    #1;
    n_checks++; if (bus.rs1_val !== 32'h0 || bus.rs1_busy !== 1'b0 || bus.rs1_tag !== 5'd0) begin n_fail++; $display("FAIL x0_after: got %h/%b/%0d want 0/0/0", bus.rs1_val, bus.rs1_busy, bus.rs1_tag); end
  endtask
  task automatic test_rdy_hold();
    rdy_in = 1'b0;
    commit(5'd1, 5'd0, 32'hABCD);
    issue(5'd2, 5'd5);
    step();
    step();
    idle();
    bus.rs1_addr_in = 5'd1;
    bus.rs2_addr_in = 5'd2;
    #1;
    n_checks++; if (bus.rs1_val !== 32'h1000) begin n_fail++; $display("FAIL rdy_hold_val: got %h want %h", bus.rs1_val, 32'h1000); end
    n_checks++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL rdy_hold_busy: got %b want 0", bus.rs2_busy); end
  endtask
  task automatic test_async_reset();
    issue(5'd3, 5'd6);
    step();
    idle();
    bus.rs1_addr_in = 5'd3;
    bus.rs2_addr_in = 5'd1;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL async_setup: got %b want 1", bus.rs1_busy); end
    rst_in = 1'b1;
    #1;
    n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs1_tag !== 5'd0) begin n_fail++; $display("FAIL async_busy: got %b/%0d want 0/0", bus.rs1_busy, bus.rs1_tag); end
    n_checks++; if (bus.rs2_val !== 32'h0) begin n_fail++; $display("FAIL async_val: got %h want 0", bus.rs2_val); end
    step();
    rst_in = 1'b0;
  endtask
  initial begin
    idle();
    bus.rs1_addr_in = '0;
    bus.rs2_addr_in = '0;
    #2;
    test_reset();
    test_rename();
    test_commit_bypass();
    test_younger_writer();
    test_commit_issue_same();
    test_clear();
    test_x0();
    test_rdy_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
